lcd_text_streamer: RTL and testbench

Parametrised successor to the fixed program ROM that drove the LCD through hand-written STO/SHL/LCD/NOP sequences. The block holds a message string set by a parameter and streams each character to the 4-bit LCD data bus as a high nibble, then a low nibble. It generates the E strobe and the inter-nibble delay in hardware. It sits between the CPU control path and the LCD pins and can run a single pass or loop continuously.

---
 rtl/lcd_text_streamer.sv | 156 +++++++++++++++
 tb/tb_lcd_text_streamer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lcd_text_streamer.sv
// Streams a parameter-defined message to a 4-bit HD44780-style LCD bus, high nibble first,
// with hardware E strobe and inter-nibble delay. Define LCD_TEXT_WRITE_EN for a writable message.
module lcd_text_streamer #(
   parameter int unsigned MSG_LEN = 9,
   parameter logic [8*MSG_LEN-1:0] MSG = "HolaMundo",
   parameter int unsigned E_CYCLES = 12,
   parameter int unsigned WAIT_CYCLES = 1005,
   parameter int unsigned IDX_W = 6
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iStart,
   input  logic             iLoop,
   input  logic             iStop,
   output logic [3:0]       oLCD_Data,
   output logic             oLCD_RS,
   output logic             oLCD_E,
   output logic             oBusy,
   output logic             oDone,
   output logic [IDX_W-1:0] oCharIndex
`ifdef LCD_TEXT_WRITE_EN
   ,
   input  logic             iWrEn,
   input  logic [IDX_W-1:0] iWrAddr,
   input  logic [7:0]       iWrData
`endif
);

   localparam int unsigned MAXC = (E_CYCLES > WAIT_CYCLES) ? E_CYCLES : WAIT_CYCLES;
   localparam int unsigned CNT_W = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      IDLE,
      HI_SETUP,
      HI_PULSE,
      HI_WAIT,
      LO_SETUP,
      LO_PULSE,
      LO_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             stop_q;
   logic [7:0]       cur_char;
   logic             last;
   logic [IDX_W-1:0] next_idx;
   logic [7:0]       nxt_char;

`ifdef LCD_TEXT_WRITE_EN
   logic [7:0] mem [MSG_LEN];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned k = 0; k < MSG_LEN; k++)
            mem[k] <= MSG[8*(MSG_LEN-1-k) +: 8];
      end else if (iWrEn) begin
         // Address decode by comparison so out-of-range writes simply match nothing
         for (int unsigned k = 0; k < MSG_LEN; k++)
            if (iWrAddr == IDX_W'(k))
               mem[k] <= iWrData;
      end
   end
`endif

   always_comb begin
      last     = (oCharIndex == IDX_W'(MSG_LEN - 1));
      next_idx = (state == IDLE || last) ? '0 : oCharIndex + 1'b1;
      nxt_char = '0;
      for (int unsigned k = 0; k < MSG_LEN; k++)
         if (next_idx == IDX_W'(k))
`ifdef LCD_TEXT_WRITE_EN
            nxt_char = mem[k];
`else
            nxt_char = MSG[8*(MSG_LEN-1-k) +: 8];
`endif
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         stop_q     <= 1'b0;
         cur_char   <= '0;
         oLCD_Data  <= '0;
         oLCD_RS    <= 1'b0;
         oLCD_E     <= 1'b0;
         oBusy      <= 1'b0;
         oDone      <= 1'b0;
         oCharIndex <= '0;
      end else begin
         oDone <= 1'b0;
         if (state != IDLE && iStop)
            stop_q <= 1'b1;
         case (state)
            IDLE: begin
               oLCD_E  <= 1'b0;
               oLCD_RS <= 1'b0;
               if (iStart) begin
                  state      <= HI_SETUP;
                  oBusy      <= 1'b1;
                  oCharIndex <= '0;
                  cur_char   <= nxt_char;
                  oLCD_Data  <= nxt_char[7:4];
                  oLCD_RS    <= 1'b1;
               end
            end
            HI_SETUP, LO_SETUP: begin
               state  <= (state == HI_SETUP) ? HI_PULSE : LO_PULSE;
               oLCD_E <= 1'b1;
               cnt    <= CNT_W'(E_CYCLES);
            end
            HI_PULSE, LO_PULSE: begin
               if (cnt == CNT_W'(1)) begin
                  state  <= (state == HI_PULSE) ? HI_WAIT : LO_WAIT;
                  oLCD_E <= 1'b0;
                  cnt    <= CNT_W'(WAIT_CYCLES);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HI_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  state     <= LO_SETUP;
                  oLCD_Data <= cur_char[3:0];
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            LO_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  if (last)
                     oDone <= 1'b1;
                  // Stop has priority over both advancing and looping
                  if (stop_q || iStop || (last && !iLoop)) begin
                     state     <= IDLE;
                     oBusy     <= 1'b0;
                     oLCD_RS   <= 1'b0;
                     oLCD_Data <= '0;
                     stop_q    <= 1'b0;
                  end else begin
                     state      <= HI_SETUP;
                     oCharIndex <= next_idx;
                     cur_char   <= nxt_char;
                     oLCD_Data  <= nxt_char[7:4];
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_streamer.sv
// Directed bench for lcd_text_streamer with MSG="Hi", E_CYCLES=2, WAIT_CYCLES=3 (12 clocks/char).
// Define LCD_TEXT_WRITE_EN to also exercise the writable-message scenario.
module tb_lcd_text_streamer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       iStart = 1'b0;
   logic       iLoop = 1'b0;
   logic       iStop = 1'b0;
   logic [3:0] oLCD_Data;
   logic       oLCD_RS;
   logic       oLCD_E;
   logic       oBusy;
   logic       oDone;
   logic [1:0] oCharIndex;
`ifdef LCD_TEXT_WRITE_EN
   logic       iWrEn = 1'b0;
   logic [1:0] iWrAddr = '0;
   logic [7:0] iWrData = '0;
`endif

   int checks = 0;
   int failures = 0;

   lcd_text_streamer #(
      .MSG_LEN(2),
      .MSG("Hi"),
      .E_CYCLES(2),
      .WAIT_CYCLES(3),
      .IDX_W(2)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .iStart(iStart),
      .iLoop(iLoop),
      .iStop(iStop),
      .oLCD_Data(oLCD_Data),
      .oLCD_RS(oLCD_RS),
      .oLCD_E(oLCD_E),
      .oBusy(oBusy),
      .oDone(oDone),
      .oCharIndex(oCharIndex)
`ifdef LCD_TEXT_WRITE_EN
      ,
      .iWrEn(iWrEn),
      .iWrAddr(iWrAddr),
      .iWrData(iWrData)
`endif
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {busy, E, RS, done, data[3:0], index[1:0]}
   function automatic logic [9:0] obs();
      return {oBusy, oLCD_E, oLCD_RS, oDone, oLCD_Data, oCharIndex};
   endfunction

   // Expected bus state t cycles after busy rises; char 1 becomes c1n from the second pass on
   function automatic logic [9:0] exp_stream(int t, logic [7:0] c1n);
      int ch;
      int pos;
      int p;
      logic [7:0] c;
      logic [3:0] nib;
      logic e;
      logic d;
      logic [1:0] idx;
      ch  = (t / 12) % 2;
      pos = t % 12;
      p   = pos % 6;
      c   = (ch == 0) ? 8'h48 : ((t < 24) ? 8'h69 : c1n);
      nib = (pos < 6) ? c[7:4] : c[3:0];
      e   = (p == 1 || p == 2);
      d   = (t > 0 && t % 24 == 0);
      idx = ch[1:0];
      return {1'b1, e, 1'b1, d, nib, idx};
   endfunction

   localparam logic [9:0] IDLE_MASK = 10'b1111_0000_11;

   task automatic run_seq(input string name, input int end_t, input logic done_end,
                          input int loop_until, input int again_t, input int stop_t,
                          input logic start_stop, input int wr_t, input logic [7:0] c1n);
      logic [9:0] e;
      int eidx;
      @(negedge Clock);
      iStart = 1'b1;
      iStop  = start_stop;
      iLoop  = (loop_until > 0);
      @(posedge Clock);
      #1 iStop = 1'b0;
      iStart = 1'b0;
      for (int t = 0; t <= end_t + 3; t++) begin
         @(negedge Clock);
         if (t < end_t) begin
            check_eq($sformatf("%s_t%0d", name, t), 32'(obs()), 32'(exp_stream(t, c1n)));
         end else begin
            eidx = ((end_t - 1) / 12) % 2;
            e = {3'b000, (t == end_t) ? done_end : 1'b0, 4'h0, eidx[1:0]};
            check_eq($sformatf("%s_idle_t%0d", name, t), 32'(obs() & IDLE_MASK), 32'(e));
         end
         iStart = (t == again_t);
         iStop  = (t == stop_t);
         iLoop  = (t < loop_until);
`ifdef LCD_TEXT_WRITE_EN
         iWrEn   = (t == wr_t || t == wr_t - 2);
         iWrAddr = (t == wr_t) ? 2'd1 : 2'd2;
         iWrData = (t == wr_t) ? 8'h21 : 8'h00;
`else
         if (wr_t >= 0 && t == wr_t) iStart = 1'b0;
`endif
      end
      iStart = 1'b0;
      iStop  = 1'b0;
      iLoop  = 1'b0;
   endtask

   initial begin
      #12;
      check_eq("reset_state", 32'(obs()), 32'h0);
      @(negedge Clock);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      check_eq("idle_after_reset", 32'(obs()), 32'h0);

      // single pass: nibbles 4,8,6,9 then done at t=24
      run_seq("single", 24, 1'b1, 0, -1, -1, 1'b0, -1, 8'h69);
      // loop for two passes, iLoop dropped during the third
      run_seq("loop", 72, 1'b1, 60, -1, -1, 1'b0, -1, 8'h69);
      // stop during HI_PULSE of char 0
      run_seq("stop", 12, 1'b0, 0, -1, 1, 1'b0, -1, 8'h69);
      // start again while busy, plus start+stop together in IDLE
      run_seq("restart", 24, 1'b1, 0, 5, -1, 1'b1, -1, 8'h69);

      // asynchronous reset during LO_PULSE of char 0
      @(negedge Clock);
      iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      repeat (7) @(negedge Clock);
      check_eq("pre_reset_lo_pulse", 32'(obs()), 32'(exp_stream(7, 8'h69)));
      #2 Reset = 1'b0;
      #1 check_eq("async_reset", 32'(obs()), 32'h0);
      @(negedge Clock);
      Reset = 1'b1;
      run_seq("after_reset", 24, 1'b1, 0, -1, -1, 1'b0, -1, 8'h69);

`ifdef LCD_TEXT_WRITE_EN
      // write 0x21 to char 1 while it is being sent; out-of-range write two cycles earlier
      run_seq("write", 48, 1'b1, 30, -1, -1, 1'b0, 14, 8'h21);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
